// File: rtl/aes_round_engine_if.sv
// Block-level bus of the iterative AES engine.
// Host side: in_valid/in_ready with plaintext and cipher key.
// Consumer side: out_valid/out_ready with the finished ciphertext.
// Key-schedule side: rnd_idx_o selects the round key; rnd_key_i returns it in the same cycle.
// The slave modport is the engine's view; master is the surrounding system's view.
interface aes_round_engine_if #(
  parameter int unsigned KEY_BITS = 128
);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        plain_text_i;
  logic [KEY_BITS-1:0] key_i;
  logic [3:0]          rnd_idx_o;
  logic [127:0]        rnd_key_i;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        cipher_o;

  modport slave (
    input  in_valid, plain_text_i, key_i, rnd_key_i, out_ready,
    output in_ready, rnd_idx_o, out_valid, cipher_o
  );

  modport master (
    output in_valid, plain_text_i, key_i, rnd_key_i, out_ready,
    input  in_ready, rnd_idx_o, out_valid, cipher_o
  );
endinterface

// File: rtl/aes_round_engine.sv
// aes_pkg: AES block type and the round transforms (SubBytes, ShiftRows, MixColumns).
// aes_round_engine: iterative AES-128/192/256 encryptor reusing one round datapath.
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : aes_round_engine_if.slave (block in, ciphertext out, round-key lookup)
//   busy_o    : high while rounds are being computed
// Byte 0 of a block is bits [127:120]; state column c holds bytes 4c..4c+3.
package aes_pkg;
  typedef logic [127:0] aes_128;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    logic [7:0] v;
    x = a;
    for (int i = 0; i < 6; i++) x = gf_mul(gf_mul(x, x), a);
    v = gf_mul(x, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_128 sub_bytes(input aes_128 s);
    aes_128 r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row r of column c takes the byte of column (c + r) mod 4.
  function automatic aes_128 shift_rows(input aes_128 s);
    aes_128 r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 8*(w + 4*c) -: 8] = s[127 - 8*(w + 4*((c + w) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic aes_128 mix_columns(input aes_128 s);
    aes_128     r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction
endpackage

module aes_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned PIPE     = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  aes_round_engine_if.slave    bus,
  output logic                 busy_o
);

  localparam int unsigned NR     = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
  localparam logic [3:0]  NR_IDX = 4'(NR);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
  end
  if (!(PIPE == 1 || PIPE == 2)) begin : g_bad_pipe
    $error("aes_round_engine: PIPE must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e     state_q;
  aes_128     data_q;
  aes_128     pipe_q;
  aes_128     cipher_q;
  logic [3:0] rnd_q;
  logic       stage_q;
  logic       out_valid_q;
  logic       busy_q;

  aes_128     key0_c;
  aes_128     sr_c;
  aes_128     mix_src_c;
  aes_128     data_d;
  logic       last_c;
  logic       accept_c;
  logic       unused_key_c;

  // Only the leading 128 key bits form the round-0 key; later round keys come from the schedule.
  assign key0_c       = bus.key_i[KEY_BITS-1 -: 128];
  assign unused_key_c = ^bus.key_i;

  // Round datapath; with PIPE=2 the MixColumns/AddRoundKey half works from pipe_q.
  assign sr_c      = shift_rows(sub_bytes(data_q));
  assign mix_src_c = (PIPE == 2) ? pipe_q : sr_c;
  assign last_c    = (rnd_q == NR_IDX);
  assign data_d    = (last_c ? mix_src_c : mix_columns(mix_src_c)) ^ bus.rnd_key_i;

  // out_ready feeds in_ready in DONE so a finished block and a new one can swap in one cycle.
  assign bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept_c     = bus.in_ready && bus.in_valid;

  assign bus.out_valid = out_valid_q;
  assign bus.cipher_o  = cipher_q;
  assign bus.rnd_idx_o = rnd_q;
  assign busy_o        = busy_q;

  // Round-counter FSM; rnd_q is kept at zero outside ROUND so it drives rnd_idx_o directly.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      pipe_q      <= '0;
      cipher_q    <= '0;
      rnd_q       <= 4'd0;
      stage_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
          if (accept_c) begin
            data_q  <= bus.plain_text_i ^ key0_c;
            rnd_q   <= 4'd1;
            stage_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (PIPE == 2 && !stage_q) begin
            pipe_q  <= sr_c;
            stage_q <= 1'b1;
          end else begin
            stage_q <= 1'b0;
            if (last_c) begin
              cipher_q    <= data_d;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              rnd_q       <= 4'd0;
              state_q     <= DONE;
            end else begin
              data_q <= data_d;
              rnd_q  <= rnd_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: four instances (AES-128/192/256 with PIPE=1, AES-128 with PIPE=2)
// share one stimulus stream and are checked against the FIPS-197 appendix C vectors.
// The key schedule feeding rnd_key_i is an independent model built here.
module tb_aes_round_engine;

  logic         clk;
  logic         nrst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] pt;
  logic [255:0] key;

  int checks;
  int errors;

  logic [7:0]   sb [256];
  logic [127:0] rk [4][16];

  aes_round_engine_if #(.KEY_BITS(128)) if0 ();
  aes_round_engine_if #(.KEY_BITS(192)) if1 ();
  aes_round_engine_if #(.KEY_BITS(256)) if2 ();
  aes_round_engine_if #(.KEY_BITS(128)) if3 ();

  logic bz [4];

  aes_round_engine #(.KEY_BITS(128), .PIPE(1)) u_a128 (.clk(clk), .nrst(nrst), .bus(if0), .busy_o(bz[0]));
  aes_round_engine #(.KEY_BITS(192), .PIPE(1)) u_a192 (.clk(clk), .nrst(nrst), .bus(if1), .busy_o(bz[1]));
  aes_round_engine #(.KEY_BITS(256), .PIPE(1)) u_a256 (.clk(clk), .nrst(nrst), .bus(if2), .busy_o(bz[2]));
  aes_round_engine #(.KEY_BITS(128), .PIPE(2)) u_p2   (.clk(clk), .nrst(nrst), .bus(if3), .busy_o(bz[3]));

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if2.in_valid = in_valid;  assign if3.in_valid = in_valid;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready; assign if3.out_ready = out_ready;
  assign if0.plain_text_i = pt; assign if1.plain_text_i = pt;
  assign if2.plain_text_i = pt; assign if3.plain_text_i = pt;
  assign if0.key_i = key[255 -: 128];
  assign if1.key_i = key[255 -: 192];
  assign if2.key_i = key;
  assign if3.key_i = key[255 -: 128];
  assign if0.rnd_key_i = rk[0][if0.rnd_idx_o];
  assign if1.rnd_key_i = rk[1][if1.rnd_idx_o];
  assign if2.rnd_key_i = rk[2][if2.rnd_idx_o];
  assign if3.rnd_key_i = rk[3][if3.rnd_idx_o];

  logic         ov [4];
  logic         ir [4];
  logic [3:0]   ri [4];
  logic [127:0] ct [4];
  assign ov[0] = if0.out_valid; assign ov[1] = if1.out_valid; assign ov[2] = if2.out_valid; assign ov[3] = if3.out_valid;
  assign ir[0] = if0.in_ready;  assign ir[1] = if1.in_ready;  assign ir[2] = if2.in_ready;  assign ir[3] = if3.in_ready;
  assign ri[0] = if0.rnd_idx_o; assign ri[1] = if1.rnd_idx_o; assign ri[2] = if2.rnd_idx_o; assign ri[3] = if3.rnd_idx_o;
  assign ct[0] = if0.cipher_o;  assign ct[1] = if1.cipher_o;  assign ct[2] = if2.cipher_o;  assign ct[3] = if3.cipher_o;

  // Expected results per instance: FIPS-197 C.1 / C.2 / C.3 / C.1.
  logic [127:0] exp_ct [4];
  int           lat    [4];
  int           pipe_d [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  // Reference S-box by exhaustive search for the multiplicative inverse.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input int d, input int nk, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = k[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) rk[d][r] = '0;
    for (int r = 0; r <= nr; r++) rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic accept_idle();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid  = 1'b0;
  endtask

  // Called right after the accept edge: follows rnd_idx_o, out_valid and busy_o for 30 cycles.
  task automatic track(input string tag);
    for (int j = 0; j <= 30; j++) begin
      for (int d = 0; d < 4; d++) begin
        check($sformatf("%s_rnd%0d_j%0d", tag, d, j), ri[d],
              (j < lat[d]) ? 128'(j / pipe_d[d] + 1) : 128'd0);
        check($sformatf("%s_ov%0d_j%0d", tag, d, j), ov[d], (j >= lat[d]) ? 128'd1 : 128'd0);
        check($sformatf("%s_busy%0d_j%0d", tag, d, j), bz[d], (j < lat[d]) ? 128'd1 : 128'd0);
      end
      if (j < 30) step();
    end
    for (int d = 0; d < 4; d++) check($sformatf("%s_ct%0d", tag, d), ct[d], exp_ct[d]);
  endtask

  int acc [4];
  int dn  [4];

  initial begin
    checks    = 0;
    errors    = 0;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pt  = 128'h00112233445566778899aabbccddeeff;
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    exp_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exp_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    exp_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    exp_ct[3] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    lat[0] = 10; lat[1] = 12; lat[2] = 14; lat[3] = 20;
    pipe_d[0] = 1; pipe_d[1] = 1; pipe_d[2] = 1; pipe_d[3] = 2;
    build_sbox();
    expand(0, 4, key);
    expand(1, 6, key);
    expand(2, 8, key);
    expand(3, 4, key);

    // Reset values.
    step();
    step();
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_ir%0d", d), ir[d], 128'd1);
      check($sformatf("rst_ov%0d", d), ov[d], 128'd0);
      check($sformatf("rst_rnd%0d", d), ri[d], 128'd0);
      check($sformatf("rst_ct%0d", d), ct[d], 128'd0);
      check($sformatf("rst_busy%0d", d), bz[d], 128'd0);
    end
    #3 nrst = 1'b1;
    step();

    // FIPS-197 vectors, latency and round-index sequence.
    accept_idle();
    track("fips");

    // Backpressure: results held, no new block taken while out_ready is low.
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int d = 0; d < 4; d++) begin
        check($sformatf("bp_ir%0d_c%0d", d, c), ir[d], 128'd0);
        check($sformatf("bp_ov%0d_c%0d", d, c), ov[d], 128'd1);
        check($sformatf("bp_ct%0d_c%0d", d, c), ct[d], exp_ct[d]);
        check($sformatf("bp_busy%0d_c%0d", d, c), bz[d], 128'd0);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) check($sformatf("bp_ir_open%0d", d), ir[d], 128'd1);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    track("bp");

    // Random handshake stalls: every delivered block correct, none lost or duplicated.
    for (int d = 0; d < 4; d++) begin
      acc[d] = 1;
      dn[d]  = 0;
    end
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int d = 0; d < 4; d++) begin
        if (in_valid && ir[d]) acc[d]++;
        if (ov[d] && out_ready) begin
          dn[d]++;
          check($sformatf("st_ct%0d_c%0d", d, c), ct[d], exp_ct[d]);
        end
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      for (int d = 0; d < 4; d++) if (ov[d]) dn[d]++;
      step();
    end
    for (int d = 0; d < 4; d++) check($sformatf("st_count%0d", d), 128'(dn[d]), 128'(acc[d]));

    // Asynchronous reset during round 5.
    accept_idle();
    for (int j = 0; j < 4; j++) step();
    check("mid_rnd_before_rst", ri[0], 128'd5);
    #1 nrst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("ar_ir%0d", d), ir[d], 128'd1);
      check($sformatf("ar_ov%0d", d), ov[d], 128'd0);
      check($sformatf("ar_rnd%0d", d), ri[d], 128'd0);
      check($sformatf("ar_ct%0d", d), ct[d], 128'd0);
      check($sformatf("ar_busy%0d", d), bz[d], 128'd0);
    end
    step();
    #3 nrst = 1'b1;
    for (int c = 0; c < 25; c++) begin
      step();
      for (int d = 0; d < 4; d++) check($sformatf("ar_noov%0d_c%0d", d, c), ov[d], 128'd0);
    end
    accept_idle();
    track("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
